// File: rtl/fpu_result_commit_if.sv
// Handshake/data bundle between the FPU exception stage, the result commit
// buffer and the downstream consumer. The master modport is the side that
// produces results and consumes commits (the environment); the slave modport
// is the commit block itself.
interface fpu_result_commit_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] fp_operation;
    logic       op_is_exception;
    logic [2:0] fp_exce;
    logic [7:0] raw_result;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] fp_result;
    logic [2:0] fp_flags;
    logic       flag_clear;

    modport master (
        output in_valid, fp_operation, op_is_exception, fp_exce, raw_result,
               out_ready, flag_clear,
        input  in_ready, out_valid, fp_result, fp_flags
    );

    modport slave (
        input  in_valid, fp_operation, op_is_exception, fp_exce, raw_result,
               out_ready, flag_clear,
        output in_ready, out_valid, fp_result, fp_flags
    );
endinterface

// File: rtl/fpu_result_commit.sv
// FPU result commit buffer.
// Classifies each accepted result, substitutes NaN / signed infinity / signed
// zero as required, queues it in a DEPTH-entry FIFO (DEPTH = 2 or 4) and
// accumulates sticky exception flags at accept time.
// Optional feature: define EXCE_COUNT_EN to add the saturating exception
// counter and its exce_count output port.
module fpu_result_commit #(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    fpu_result_commit_if.slave        bus
`ifdef EXCE_COUNT_EN
    ,
    output logic [7:0]                exce_count
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        CLS_PASS = 2'b00,
        CLS_NAN  = 2'b01,
        CLS_INF  = 2'b10,
        CLS_ZERO = 2'b11
    } cls_e;

    // Priority classification: any invalid/reserved indication wins over
    // overflow, which wins over underflow.
    function automatic cls_e classify(input logic [1:0] op,
                                      input logic       op_exc,
                                      input logic [2:0] exce);
        cls_e cls;
        if (op_exc || (op == 2'b11) || exce[2]) begin
            cls = CLS_NAN;
        end else begin
            case (exce[1:0])
                2'b01:   cls = CLS_NAN;
                2'b10:   cls = CLS_INF;
                2'b11:   cls = CLS_ZERO;
                default: cls = CLS_PASS;
            endcase
        end
        return cls;
    endfunction

    // Value committed for a given class; infinity and zero keep the raw sign.
    function automatic logic [7:0] substitute(input cls_e cls, input logic [7:0] raw);
        logic [7:0] val;
        case (cls)
            CLS_NAN:  val = 8'h7F;
            CLS_INF:  val = {raw[7], 7'h78};
            CLS_ZERO: val = {raw[7], 7'h00};
            default:  val = raw;
        endcase
        return val;
    endfunction

    // Sticky flag bit that a class contributes.
    function automatic logic [2:0] flag_bits(input cls_e cls);
        logic [2:0] fb;
        case (cls)
            CLS_NAN:  fb = 3'b001;
            CLS_INF:  fb = 3'b010;
            CLS_ZERO: fb = 3'b100;
            default:  fb = 3'b000;
        endcase
        return fb;
    endfunction

    logic [7:0]    mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r, rd_ptr_nx;
    logic [PW-1:0] wr_ptr_r, wr_ptr_nx;
    logic [CW-1:0] count_r, count_nx;
    logic [CW-1:0] count_after_pop_s;
    logic          in_ready_r, in_ready_nx;
    logic          out_valid_r, out_valid_nx;
    logic [7:0]    fp_result_r, fp_result_nx;
    logic [2:0]    flags_r, flags_nx;
    logic          push_s;
    logic          pop_s;
    cls_e          cls_s;
    logic [7:0]    entry_s;

    // Handshakes, classification and all next-state values.
    always_comb begin
        push_s            = bus.in_valid & in_ready_r;
        pop_s             = out_valid_r & bus.out_ready;
        cls_s             = classify(bus.fp_operation, bus.op_is_exception, bus.fp_exce);
        entry_s           = substitute(cls_s, bus.raw_result);
        count_nx          = count_r;
        rd_ptr_nx         = rd_ptr_r;
        wr_ptr_nx         = wr_ptr_r;
        fp_result_nx      = fp_result_r;
        flags_nx          = flags_r;
        count_after_pop_s = count_r - {{(CW-1){1'b0}}, pop_s};

        case ({push_s, pop_s})
            2'b10:   count_nx = count_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_nx = count_r - {{(CW-1){1'b0}}, 1'b1};
            default: count_nx = count_r;
        endcase

        if (pop_s) begin
            rd_ptr_nx = rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_nx = rd_ptr_r;
        end

        if (push_s) begin
            wr_ptr_nx = wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_nx = wr_ptr_r;
        end

        // Registered head: hold when empty, bypass the new entry when it
        // becomes the only one, otherwise present the stored next head.
        if (count_nx == {CW{1'b0}}) begin
            fp_result_nx = fp_result_r;
        end else if (count_after_pop_s == {CW{1'b0}}) begin
            fp_result_nx = entry_s;
        end else begin
            fp_result_nx = mem_r[rd_ptr_nx];
        end

        // Clear first, then OR in this cycle's accept.
        if (bus.flag_clear) begin
            flags_nx = 3'b000;
        end else begin
            flags_nx = flags_r;
        end
        if (push_s) begin
            flags_nx = flags_nx | flag_bits(cls_s);
        end else begin
            flags_nx = flags_nx;
        end

        // Ready depends on occupancy only, never on a same-cycle pop.
        in_ready_nx  = (count_nx < DEPTH_C);
        out_valid_nx = (count_nx != {CW{1'b0}});
    end

    // FIFO storage, pointers, occupancy and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            rd_ptr_r    <= {PW{1'b0}};
            wr_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            fp_result_r <= 8'h00;
            flags_r     <= 3'b000;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= entry_s;
            end
            rd_ptr_r    <= rd_ptr_nx;
            wr_ptr_r    <= wr_ptr_nx;
            count_r     <= count_nx;
            in_ready_r  <= in_ready_nx;
            out_valid_r <= out_valid_nx;
            fp_result_r <= fp_result_nx;
            flags_r     <= flags_nx;
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.fp_result = fp_result_r;
    assign bus.fp_flags  = flags_r;

`ifdef EXCE_COUNT_EN
    logic [7:0] exce_count_r, exce_count_nx;

    // Saturating count of non-passthrough accepts; clear applies before the increment.
    always_comb begin
        if (bus.flag_clear) begin
            exce_count_nx = 8'h00;
        end else begin
            exce_count_nx = exce_count_r;
        end
        if (push_s && (cls_s != CLS_PASS) && (exce_count_nx != 8'hFF)) begin
            exce_count_nx = exce_count_nx + 8'h01;
        end else begin
            exce_count_nx = exce_count_nx;
        end
    end

    // Exception counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exce_count_r <= 8'h00;
        end else begin
            exce_count_r <= exce_count_nx;
        end
    end

    assign exce_count = exce_count_r;
`endif

endmodule

// File: tb/tb_fpu_result_commit.sv
// Directed self-checking bench for fpu_result_commit (DEPTH = 2).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_fpu_result_commit;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    fpu_result_commit_if bus();

`ifdef EXCE_COUNT_EN
    logic [7:0] exce_count;
`endif

    fpu_result_commit #(.DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef EXCE_COUNT_EN
        ,
        .exce_count (exce_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic v, input logic [1:0] op, input logic oe,
                          input logic [2:0] ex, input logic [7:0] raw);
        bus.in_valid        = v;
        bus.fp_operation    = op;
        bus.op_is_exception = oe;
        bus.fp_exce         = ex;
        bus.raw_result      = raw;
    endtask

    // Push one entry while popping whatever is at the head, then go idle.
    task automatic send(input logic [1:0] op, input logic oe,
                        input logic [2:0] ex, input logic [7:0] raw);
        set_in(1'b1, op, oe, ex, raw);
        bus.out_ready = 1'b1;
        tick();
        set_in(1'b0, 2'b00, 1'b0, 3'b000, 8'h00);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        set_in(1'b0, 2'b00, 1'b0, 3'b000, 8'h00);
        bus.out_ready  = 1'b0;
        bus.flag_clear = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_result", 32'(bus.fp_result), 32'h00);
        chk("rst_flags", 32'(bus.fp_flags), 32'h0);
`ifdef EXCE_COUNT_EN
        chk("rst_count", 32'(exce_count), 32'h00);
`endif
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", 32'(bus.in_ready), 32'h1);

        // Passthrough with one-cycle latency, then pop to empty
        send(2'b00, 1'b0, 3'b000, 8'h3A);
        chk("pass_valid", 32'(bus.out_valid), 32'h1);
        chk("pass_result", 32'(bus.fp_result), 32'h3A);
        chk("pass_flags", 32'(bus.fp_flags), 32'h0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("empty_valid", 32'(bus.out_valid), 32'h0);
        chk("empty_hold", 32'(bus.fp_result), 32'h3A);

        // Substitution vectors (each send pops the previous result)
        send(2'b00, 1'b1, 3'b000, 8'h3A);
        chk("sub_opexc", 32'(bus.fp_result), 32'h7F);
        chk("sub_opexc_fl", 32'(bus.fp_flags), 32'h1);
        send(2'b00, 1'b0, 3'b010, 8'h85);
        chk("sub_ovf_neg", 32'(bus.fp_result), 32'hF8);
        chk("sub_ovf_fl", 32'(bus.fp_flags), 32'h3);
        send(2'b00, 1'b0, 3'b011, 8'h01);
        chk("sub_unf_pos", 32'(bus.fp_result), 32'h00);
        chk("sub_unf_fl", 32'(bus.fp_flags), 32'h7);
        send(2'b11, 1'b0, 3'b000, 8'h12);
        chk("sub_op_rsvd", 32'(bus.fp_result), 32'h7F);
        send(2'b01, 1'b0, 3'b100, 8'h12);
        chk("sub_exce_rsvd", 32'(bus.fp_result), 32'h7F);
        send(2'b10, 1'b0, 3'b011, 8'h81);
        chk("sub_unf_neg", 32'(bus.fp_result), 32'h80);
        send(2'b00, 1'b0, 3'b010, 8'h05);
        chk("sub_ovf_pos", 32'(bus.fp_result), 32'h78);
        send(2'b10, 1'b1, 3'b010, 8'h05);
        chk("sub_prio_nan", 32'(bus.fp_result), 32'h7F);
`ifdef EXCE_COUNT_EN
        chk("count_8", 32'(exce_count), 32'h08);
`endif
        bus.out_ready  = 1'b1;
        bus.flag_clear = 1'b1;
        tick();
        bus.out_ready  = 1'b0;
        bus.flag_clear = 1'b0;
        chk("clear_flags", 32'(bus.fp_flags), 32'h0);
        chk("clear_empty", 32'(bus.out_valid), 32'h0);

        // Backpressure: two pushes fill the buffer, third is refused
        set_in(1'b1, 2'b00, 1'b0, 3'b000, 8'h11);
        tick();
        chk("bp_ready1", 32'(bus.in_ready), 32'h1);
        bus.raw_result = 8'h22;
        tick();
        chk("bp_ready_full", 32'(bus.in_ready), 32'h0);
        bus.raw_result = 8'h33;
        tick();
        chk("bp_hold", 32'(bus.fp_result), 32'h11);
        set_in(1'b0, 2'b00, 1'b0, 3'b000, 8'h00);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_pop2", 32'(bus.fp_result), 32'h22);
        chk("bp_pop2_v", 32'(bus.out_valid), 32'h1);
        tick();
        chk("bp_no_third", 32'(bus.out_valid), 32'h0);
        chk("bp_ready_back", 32'(bus.in_ready), 32'h1);
        bus.out_ready = 1'b0;

        // Full with pop pending: ready stays low that cycle, then push+pop
        set_in(1'b1, 2'b00, 1'b0, 3'b000, 8'h44);
        tick();
        bus.raw_result = 8'h55;
        tick();
        bus.raw_result = 8'h66;
        bus.out_ready  = 1'b1;
        tick();
        chk("pp_head55", 32'(bus.fp_result), 32'h55);
        chk("pp_ready", 32'(bus.in_ready), 32'h1);
        tick();
        chk("pp_head66", 32'(bus.fp_result), 32'h66);
        chk("pp_valid", 32'(bus.out_valid), 32'h1);
        bus.raw_result = 8'h77;
        bus.out_ready  = 1'b0;
        tick();
        chk("pp_full", 32'(bus.in_ready), 32'h0);
        set_in(1'b0, 2'b00, 1'b0, 3'b000, 8'h00);
        bus.out_ready = 1'b1;
        tick();
        chk("pp_head77", 32'(bus.fp_result), 32'h77);
        tick();
        chk("pp_drained", 32'(bus.out_valid), 32'h0);
        bus.out_ready = 1'b0;

        // Clear in the same cycle as an invalid accept
        send(2'b00, 1'b0, 3'b010, 8'h01);
        chk("pre_clear_fl", 32'(bus.fp_flags), 32'h2);
        bus.flag_clear = 1'b1;
        send(2'b00, 1'b0, 3'b001, 8'h01);
        bus.flag_clear = 1'b0;
        chk("clear_set_fl", 32'(bus.fp_flags), 32'h1);
`ifdef EXCE_COUNT_EN
        chk("clear_set_cnt", 32'(exce_count), 32'h01);
`endif

        // 300 back-to-back exception accepts with continuous draining
        set_in(1'b1, 2'b00, 1'b1, 3'b000, 8'h00);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        set_in(1'b0, 2'b00, 1'b0, 3'b000, 8'h00);
        tick();
        bus.out_ready = 1'b0;
        chk("stream_drained", 32'(bus.out_valid), 32'h0);
`ifdef EXCE_COUNT_EN
        chk("count_sat", 32'(exce_count), 32'hFF);
`endif

        // Reset with two entries buffered
        send(2'b00, 1'b0, 3'b010, 8'h01);
        set_in(1'b1, 2'b00, 1'b0, 3'b000, 8'h5A);
        tick();
        set_in(1'b0, 2'b00, 1'b0, 3'b000, 8'h00);
        chk("prerst_full", 32'(bus.in_ready), 32'h0);
        chk("prerst_fl", 32'(bus.fp_flags), 32'h3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("mid_rst_flags", 32'(bus.fp_flags), 32'h0);
        chk("mid_rst_result", 32'(bus.fp_result), 32'h00);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'h0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_nopop", 32'(bus.out_valid), 32'h0);
        end
        chk("post_rst_ready", 32'(bus.in_ready), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
